// File: rtl/maxpool2d_stream.sv
// Streaming 2x2 / stride-2 max-pool over raster-ordered multi-channel pixels.
// A half-width line buffer keeps the horizontal pair maxima from each even
// row; the matching odd row closes the window and emits one pooled pixel.
//
// Handshake: in_valid marks a beat that is always consumed (no backpressure);
// out_valid is a one-cycle pulse with out_data/out_last valid in that cycle,
// and out_data keeps its last value while out_valid is low.
module maxpool2d_stream #(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 2,
  parameter int IMG_W    = 6,
  parameter int IMG_H    = 6,
  parameter int SIGNED   = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  output logic                         out_valid,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  output logic                         out_last,
  output logic                         busy
);

  localparam int PW   = CHANNELS * DATA_W;
  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LB_D = IMG_W / 2;
  localparam int LBW  = (LB_D > 1) ? $clog2(LB_D) : 1;

  localparam logic [CW-1:0] COL_LAST     = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST     = RW'(IMG_H - 1);
  // Position of the last window-closing pixel (accounts for floor cropping).
  localparam logic [CW-1:0] COL_OUT_LAST = CW'((IMG_W / 2) * 2 - 1);
  localparam logic [RW-1:0] ROW_OUT_LAST = RW'((IMG_H / 2) * 2 - 1);
  localparam bit            ODD_H        = (IMG_H % 2) == 1;

  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [PW-1:0]  hold;
  logic [PW-1:0]  line_buf [LB_D];
  logic [LBW-1:0] lb_idx;
  logic           col_odd;
  logic           row_odd;
  logic           row_cropped;
  logic [PW-1:0]  pair_max;
  logic [PW-1:0]  win_max;

  assign lb_idx      = LBW'(col >> 1);
  assign col_odd     = col[0];
  assign row_odd     = row[0];
  // Trailing row of an odd-height image belongs to no window.
  assign row_cropped = ODD_H && (row == ROW_LAST);
  assign busy        = (col != '0) || (row != '0);

  // Per-channel maximum under the configured signedness.
  function automatic logic [DATA_W-1:0] ch_max(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic a_wins;
    if (SIGNED != 0) a_wins = $signed(a) > $signed(b);
    else             a_wins = a > b;
    return a_wins ? a : b;
  endfunction

  // Horizontal pair max and full 2x2 window max, channel by channel.
  always_comb begin
    pair_max = '0;
    win_max  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      pair_max[k*DATA_W +: DATA_W] = ch_max(hold[k*DATA_W +: DATA_W],
                                            in_data[k*DATA_W +: DATA_W]);
      win_max[k*DATA_W +: DATA_W]  = ch_max(line_buf[lb_idx][k*DATA_W +: DATA_W],
                                            pair_max[k*DATA_W +: DATA_W]);
    end
  end

  // Frame position, horizontal hold register and registered output.
  always_ff @(posedge clk) begin
    if (reset) begin
      col       <= '0;
      row       <= '0;
      hold      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      if (in_valid) begin
        if (!col_odd) hold <= in_data;
        if (col_odd && row_odd) begin
          out_valid <= 1'b1;
          out_data  <= win_max;
          out_last  <= (row == ROW_OUT_LAST) && (col == COL_OUT_LAST);
        end
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Line buffer: pair maxima of even rows, consumed on the following odd row.
  always_ff @(posedge clk) begin
    if (!reset && in_valid && col_odd && !row_odd && !row_cropped)
      line_buf[lb_idx] <= pair_max;
  end

endmodule

// File: tb/tb_maxpool2d_stream.sv
// Bench for maxpool2d_stream: three instances (default 6x6 unsigned,
// 2x2 signed, 5x5 odd-size) driven from whole-frame images; the expected
// pooled pixels come from direct 2x2 maxima over the stored image.
module tb_maxpool2d_stream;

  typedef struct packed {
    logic        last;
    logic [15:0] data;
    logic [31:0] due;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_seen = 1'b1;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  // ---------------- DUT instances ----------------
  logic        va = 0, vb = 0, vc = 0;
  logic [15:0] da = 0, db = 0, dc = 0;
  logic        ova, ovb, ovc, ola, olb, olc, busy_a, busy_b, busy_c;
  logic [15:0] oda, odb, odc;

  maxpool2d_stream #(.DATA_W(8), .CHANNELS(2), .IMG_W(6), .IMG_H(6), .SIGNED(0)) dut_a (
    .clk(clk), .reset(reset), .in_valid(va), .in_data(da),
    .out_valid(ova), .out_data(oda), .out_last(ola), .busy(busy_a));

  maxpool2d_stream #(.DATA_W(8), .CHANNELS(2), .IMG_W(2), .IMG_H(2), .SIGNED(1)) dut_b (
    .clk(clk), .reset(reset), .in_valid(vb), .in_data(db),
    .out_valid(ovb), .out_data(odb), .out_last(olb), .busy(busy_b));

  maxpool2d_stream #(.DATA_W(8), .CHANNELS(2), .IMG_W(5), .IMG_H(5), .SIGNED(0)) dut_c (
    .clk(clk), .reset(reset), .in_valid(vc), .in_data(dc),
    .out_valid(ovc), .out_data(odc), .out_last(olc), .busy(busy_c));

  // ---------------- scoreboard state ----------------
  exp_t        exp_q_a[$], exp_q_b[$], exp_q_c[$];
  logic [15:0] obs_a[$], obs_b[$], obs_c[$];
  logic [15:0] prev [3];
  logic [15:0] frame [0:5][0:5];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input logic [63:0] got,
                              input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  function automatic int total_pending();
    return exp_q_a.size() + exp_q_b.size() + exp_q_c.size();
  endfunction

  // ---------------- monitor ----------------
  function automatic void mon_step(input int inst, input logic v, input logic l,
                                   input logic [15:0] d);
    exp_t e;
    bit   have;
    e = '0;
    have = 1'b0;
    if (rst_seen) begin
      chk("reset_out_valid", {63'd0, v}, 64'd0);
      chk("reset_out_data", {48'd0, d}, 64'd0);
      prev[inst] = '0;
      return;
    end
    if (v) begin
      case (inst)
        0: if (exp_q_a.size() > 0) begin e = exp_q_a.pop_front(); have = 1'b1; end
        1: if (exp_q_b.size() > 0) begin e = exp_q_b.pop_front(); have = 1'b1; end
        default: if (exp_q_c.size() > 0) begin e = exp_q_c.pop_front(); have = 1'b1; end
      endcase
      case (inst)
        0: obs_a.push_back(d);
        1: obs_b.push_back(d);
        default: obs_c.push_back(d);
      endcase
      chk($sformatf("output_expected_i%0d", inst), {63'd0, have}, 64'd1);
      if (have) begin
        chk($sformatf("out_data_i%0d", inst), {48'd0, d}, {48'd0, e.data});
        chk($sformatf("out_last_i%0d", inst), {63'd0, l}, {63'd0, e.last});
        chk($sformatf("latency_i%0d", inst), 64'(cyc), {32'd0, e.due});
      end
      prev[inst] = d;
    end else begin
      chk($sformatf("hold_data_i%0d", inst), {48'd0, d}, {48'd0, prev[inst]});
      chk($sformatf("last_low_i%0d", inst), {63'd0, l}, 64'd0);
    end
  endfunction

  always @(negedge clk) begin
    mon_step(0, ova, ola, oda);
    mon_step(1, ovb, olb, odb);
    mon_step(2, ovc, olc, odc);
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] window_max(input int r, input int c, input bit sgn);
    logic [15:0] res;
    logic [15:0] pix;
    int m, v;
    res = '0;
    for (int ch = 0; ch < 2; ch++) begin
      m = -100000;
      for (int dr = 0; dr < 2; dr++)
        for (int dc2 = 0; dc2 < 2; dc2++) begin
          pix = frame[r-1+dr][c-1+dc2];
          v = sgn ? int'($signed(pix[ch*8 +: 8])) : int'(pix[ch*8 +: 8]);
          if (v > m) m = v;
        end
      res[ch*8 +: 8] = 8'(m);
    end
    return res;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input int inst, input logic v, input logic [15:0] d);
    case (inst)
      0: begin va = v; da = d; end
      1: begin vb = v; db = d; end
      default: begin vc = v; dc = d; end
    endcase
  endtask

  function automatic logic busy_of(input int inst);
    case (inst)
      0: return busy_a;
      1: return busy_b;
      default: return busy_c;
    endcase
  endfunction

  task automatic push_exp(input int inst, input exp_t e);
    case (inst)
      0: exp_q_a.push_back(e);
      1: exp_q_b.push_back(e);
      default: exp_q_c.push_back(e);
    endcase
  endtask

  // Stream the stored image (first nbeats pixels) with random idle gaps.
  task automatic send_frame(input int inst, input int w, input int h, input bit sgn,
                            input int max_gap, input int nbeats);
    exp_t e;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        if (r * w + c >= nbeats) begin
          drive(inst, 1'b0, '0);
          return;
        end
        repeat ($urandom_range(max_gap, 0)) begin
          drive(inst, 1'b0, 16'($urandom));
          @(posedge clk); #1;
        end
        chk($sformatf("busy_i%0d", inst), {63'd0, busy_of(inst)}, {63'd0, (r * w + c) != 0});
        drive(inst, 1'b1, frame[r][c]);
        if ((r % 2 == 1) && (c % 2 == 1) && (r < (h / 2) * 2) && (c < (w / 2) * 2)) begin
          e.data = window_max(r, c, sgn);
          e.last = (r == (h / 2) * 2 - 1) && (c == (w / 2) * 2 - 1);
          e.due  = 32'(cyc + 1);
          push_exp(inst, e);
        end
        @(posedge clk); #1;
      end
    drive(inst, 1'b0, '0);
  endtask

  task automatic fill_ramp(input int w);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        frame[r][c] = {8'(255 - (w * r + c)), 8'(w * r + c)};
  endtask

  task automatic fill_random();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        frame[r][c] = 16'($urandom);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (total_pending() != 0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (2) begin @(posedge clk); #1; end
    chk("drain_pending", 64'(total_pending()), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  int base;
  int ref5 [4] = '{6, 8, 16, 18};

  initial begin
    prev[0] = '0; prev[1] = '0; prev[2] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy_a", {63'd0, busy_a}, 64'd0);
    reset = 1'b0;

    // Ramp, back to back.
    fill_ramp(6);
    base = obs_a.size();
    send_frame(0, 6, 6, 0, 0, 36);
    drain();
    chk("ramp_count", 64'(obs_a.size() - base), 64'd9);
    chk("ramp_first", {48'd0, obs_a[base]}, 64'hFF07);
    chk("ramp_ninth", {48'd0, obs_a[base + 8]}, 64'hE323);

    // Same ramp with random gaps.
    base = obs_a.size();
    send_frame(0, 6, 6, 0, 3, 36);
    drain();
    chk("gap_count", 64'(obs_a.size() - base), 64'd9);
    chk("gap_ninth", {48'd0, obs_a[base + 8]}, 64'hE323);

    // Random frames.
    for (int f = 0; f < 3; f++) begin
      fill_random();
      send_frame(0, 6, 6, 0, (f == 0) ? 0 : 2, 36);
    end
    drain();

    // Two consecutive frames with no gap.
    fill_ramp(6);
    base = obs_a.size();
    send_frame(0, 6, 6, 0, 0, 36);
    send_frame(0, 6, 6, 0, 0, 36);
    drain();
    chk("two_frame_count", 64'(obs_a.size() - base), 64'd18);
    chk("two_frame_second", {48'd0, obs_a[base + 9]}, {48'd0, obs_a[base]});

    // Reset mid-frame, then a full frame.
    send_frame(0, 6, 6, 0, 0, 20);
    drain();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("busy_after_reset", {63'd0, busy_a}, 64'd0);
    // Reset together with in_valid drops the beat.
    reset = 1'b1;
    drive(0, 1'b1, 16'hABCD);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, 1'b0, '0);
    chk("busy_after_reset_beat", {63'd0, busy_a}, 64'd0);
    base = obs_a.size();
    send_frame(0, 6, 6, 0, 1, 36);
    drain();
    chk("post_reset_count", 64'(obs_a.size() - base), 64'd9);
    chk("post_reset_first", {48'd0, obs_a[base]}, 64'hFF07);

    // Signed windows.
    frame[0][0] = 16'hF9FB;
    frame[0][1] = 16'hFE80;
    frame[1][0] = 16'hF703;
    frame[1][1] = 16'hFDFF;
    base = obs_b.size();
    send_frame(1, 2, 2, 1, 0, 4);
    drain();
    chk("signed_window", {48'd0, obs_b[base]}, 64'hFE03);
    for (int f = 0; f < 6; f++) begin
      fill_random();
      send_frame(1, 2, 2, 1, 2, 4);
    end
    drain();

    // Odd-sized image with cropping.
    fill_ramp(5);
    base = obs_c.size();
    send_frame(2, 5, 5, 0, 0, 25);
    drain();
    chk("odd_count", 64'(obs_c.size() - base), 64'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("odd_ch0_%0d", k), {56'd0, obs_c[base + k][7:0]}, 64'(ref5[k]));
    for (int f = 0; f < 2; f++) begin
      fill_random();
      send_frame(2, 5, 5, 0, 2, 25);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "time limit");
  end

endmodule
